mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
//
// PURPOSE
//  Load/store sequencer sitting directly upstream of the byte-wide data memory (8-bit MEM_WIDTH).
//  Accepts one MIPS LB/LBU/LH/LHU/LW/SB/SH/SW request from the MEM stage over a valid/ready handshake.
//  Splits each request into 1/2/4 single-byte memory transfers, big-endian (byte at lowest address = MSB).
//  Reassembles and extends load data, and flags misaligned or reserved-size requests without touching memory.
//
// PARAMETERS
//  ADDR_WIDTH   32  byte-address width; address arithmetic wraps modulo 2^ADDR_WIDTH
//  MEM_LATENCY  1   cycles from mem_rden cycle to the cycle mem_rdata is valid (>=1)
//
// PORTS
//  clock         in   1           single clock, all state on posedge
//  reset_n       in   1           asynchronous, active-low reset
//  req_valid     in   1           request present
//  req_ready     out  1           unit can accept; =1 only in IDLE
//  req_we        in   1           1=store, 0=load
//  req_size      in   2           00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1           loads: 1=zero-extend, 0=sign-extend; ignored for stores
//  req_addr      in   ADDR_WIDTH  byte address
//  req_wdata     in   32          store data, right-justified
//  resp_valid    out  1           one-cycle completion pulse, no backpressure
//  resp_rdata    out  32          extended load data; 0 for stores and errors
//  resp_error    out  1           valid with resp_valid: misaligned or size 11
//  mem_address   out  ADDR_WIDTH  byte address to memory
//  mem_wdata     out  8           byte to write
//  mem_wren      out  1           write strobe, one cycle per byte
//  mem_rden      out  1           read strobe, one cycle per byte
//  mem_rdata     in   8           read byte, valid MEM_LATENCY cycles after mem_rden
//
// BEHAVIOUR
//  - States: IDLE, XFER, WAIT, RESP. All outputs registered except req_ready = (state==IDLE).
//  - Reset (async, any state): state IDLE; resp_valid/resp_error/mem_wren/mem_rden = 0.
//    mem_address/mem_wdata/resp_rdata and the byte counter = 0; a partially written store stays partial.
//  - Accept on posedge with req_valid & req_ready; all req_* latched; req_* ignored while busy.
//  - N = 1/2/4 for size 00/01/10. Error if size 11, half with addr[0]!=0, or word with addr[1:0]!=0.
//  - Error path: IDLE->RESP; resp_valid=resp_error=1 and resp_rdata=0 in cycle C1; no mem strobes.
//  - Byte k (0..N-1) uses mem_address = addr+k, wrapping modulo 2^ADDR_WIDTH.
//  - Store byte k: mem_wdata = wdata[8N-1-8k -: 8]. XFER occupies C1..CN with mem_wren=1 each cycle.
//    Store: RESP in C(N+1); IDLE in C(N+2).
//  - Load byte k: one XFER cycle with mem_rden=1, then MEM_LATENCY WAIT cycles.
//    mem_rdata is captured at the edge ending the last WAIT cycle and shifted in: acc = {acc[23:0], byte}.
//    Load: N*(1+MEM_LATENCY) cycles of transfer, then RESP.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE. Loads return the low 8N bits of acc,
//    sign- or zero-extended to 32 bits per req_unsigned.
//  - mem_wren and mem_rden are never high together; both are 0 in IDLE, WAIT and RESP.
//  - Back-to-back: a new request is accepted in the cycle after RESP (first IDLE cycle).
//
// TESTING
//  SW 0xDEADBEEF @0x100: wren C1..C4, bytes DE,AD,BE,EF @0x100..0x103, resp C5; LW @0x100 (L=1) -> resp C9, rdata 0xDEADBEEF
//  Memory 0x80 @0x103: LB -> 0xFFFFFF80; LBU -> 0x00000080; SB 0x7F @0x103 then LB -> 0x0000007F
//  SH 0x8001 @0x102: LH -> 0xFFFF8001, LHU -> 0x00008001; LH @0x101 -> error in C1, rdata 0, no strobes
//  LW @0x102 and size=11 @0x0 -> resp_error=1 in C1, req_ready high again in C2, memory untouched
//  Drop reset_n during C3 of SW 0x11223344 @0x200 -> only 0x11,0x22 written, strobes 0 at once, next request accepted after release
//  MEM_LATENCY=2: LHU @0xFFFFFFFE of bytes AB,CD -> resp at C7, rdata 0x0000ABCD; LBU @0xFFFFFFFF -> address wraps correctly

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-wide data memory: splits MIPS byte/half/word
// requests into big-endian single-byte transfers and reassembles/extends load data.
module mem_access_unit #(
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [7:0]            mem_wdata,
   output logic                  mem_wren,
   output logic                  mem_rden,
   input  logic [7:0]            mem_rdata,
   output logic [1:0]            o_dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
   // high; req_ready depends only on the state. resp_valid is a single-cycle pulse with no
   // backpressure.

   localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   logic                  r_we;
   logic [1:0]            r_last;      // index of the final byte: 0, 1 or 3
   logic                  r_unsigned;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [1:0]            r_cnt;
   logic [WW-1:0]         r_wait;
   logic [31:0]           r_acc;
   logic                  r_resp_valid;
   logic                  r_resp_error;
   logic [31:0]           r_resp_rdata;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [7:0]            r_mem_wdata;
   logic                  r_mem_wren;
   logic                  r_mem_rden;

   logic [1:0]            w_req_last;
   logic                  w_req_err;
   logic [1:0]            w_next_k;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [31:0]           w_next_acc;

   function automatic logic [7:0] f_store_byte(input logic [31:0] data, input logic [1:0] last,
                                               input logic [1:0] k);
      logic [1:0] d;
      d = last - k;
      return data[{d, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] f_extend(input logic [31:0] acc, input logic [1:0] last,
                                            input logic uns);
      logic [31:0] res;
      case (last)
         2'd0:    res = uns ? {24'd0, acc[7:0]}  : {{24{acc[7]}}, acc[7:0]};
         2'd1:    res = uns ? {16'd0, acc[15:0]} : {{16{acc[15]}}, acc[15:0]};
         default: res = acc;
      endcase
      return res;
   endfunction

   always_comb begin
      w_req_last = 2'd0;
      case (req_size)
         2'b01:   w_req_last = 2'd1;
         2'b10:   w_req_last = 2'd3;
         default: w_req_last = 2'd0;
      endcase
      w_req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && (req_addr[1:0] != 2'b00));
   end

   assign w_next_k    = r_cnt + 2'd1;
   assign w_next_addr = r_addr + {{(ADDR_WIDTH-2){1'b0}}, w_next_k};
   assign w_next_acc  = {r_acc[23:0], mem_rdata};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_we          <= 1'b0;
         r_last        <= 2'd0;
         r_unsigned    <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_cnt         <= 2'd0;
         r_wait        <= '0;
         r_acc         <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_error  <= 1'b0;
         r_resp_rdata  <= '0;
         r_mem_address <= '0;
         r_mem_wdata   <= '0;
         r_mem_wren    <= 1'b0;
         r_mem_rden    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_last     <= w_req_last;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_cnt      <= 2'd0;
                  r_wait     <= '0;
                  r_acc      <= '0;
                  if (w_req_err) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state       <= S_XFER;
                     r_mem_address <= req_addr;
                     r_mem_wren    <= req_we;
                     r_mem_rden    <= !req_we;
                     if (req_we) r_mem_wdata <= f_store_byte(req_wdata, w_req_last, 2'd0);
                  end
               end
            end
            S_XFER: begin
               if (r_we) begin
                  if (r_cnt == r_last) begin
                     r_mem_wren   <= 1'b0;
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_cnt         <= w_next_k;
                     r_mem_address <= w_next_addr;
                     r_mem_wdata   <= f_store_byte(r_wdata, r_last, w_next_k);
                  end
               end else begin
                  r_mem_rden <= 1'b0;
                  r_wait     <= '0;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // The read byte is only valid in the last wait cycle, so capture on the edge ending it.
               if (r_wait == LAST_WAIT) begin
                  r_acc <= w_next_acc;
                  if (r_cnt == r_last) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= f_extend(w_next_acc, r_last, r_unsigned);
                  end else begin
                     r_cnt         <= w_next_k;
                     r_mem_address <= w_next_addr;
                     r_mem_rden    <= 1'b1;
                     r_state       <= S_XFER;
                  end
               end else begin
                  r_wait <= r_wait + WW'(1);
               end
            end
            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_error <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign resp_valid  = r_resp_valid;
   assign resp_error  = r_resp_error;
   assign resp_rdata  = r_resp_rdata;
   assign mem_address = r_mem_address;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wren    = r_mem_wren;
   assign mem_rden    = r_mem_rden;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Drives identical request streams into two units (read latency 1 and 2), each with its own
// byte memory, and checks responses, timing, strobes and addresses against a reference model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  valid = 2'b00;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  ref_mem [2048] = '{default: 8'h00};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [10:0] idx(input logic [31:0] a);
      return {a[31], a[9:0]};
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", name, inst, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = g + 1;
      logic        ready, rv, re, mwe, mre;
      logic [31:0] rd, ma;
      logic [7:0]  mwd, mrd;
      logic [1:0]  dbg;
      logic [43:0] exp_q [$];
      logic [7:0]  m [2048] = '{default: 8'h00};
      logic [7:0]  rpipe [L];

      mem_access_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(L)) u_dut (
         .clock(clk), .reset_n(rst_n), .req_valid(valid[g]), .req_ready(ready),
         .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
         .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv), .resp_rdata(rd),
         .resp_error(re), .mem_address(ma), .mem_wdata(mwd), .mem_wren(mwe),
         .mem_rden(mre), .mem_rdata(mrd), .o_dbg_state(dbg));

      // Memory: garbage on the data bus except exactly L cycles after a read strobe.
      always @(posedge clk) begin
         if (mwe) m[idx(ma)] <= mwd;
         rpipe[0] <= mre ? m[idx(ma)] : 8'($urandom);
         for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
      end
      assign mrd = rpipe[L-1];

      initial begin
         logic        busy;
         int          acc_cyc, nstrobe;
         logic [31:0] base;
         logic [43:0] e;
         busy = 1'b0; acc_cyc = 0; nstrobe = 0; base = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               busy = 1'b0;
               chk("rst_outs", g, {26'd0, mwe, mre, rv, re, ready, 1'b0}, 32'h2);
               chk("rst_addr", g, ma, 32'h0);
            end else begin
               if (mwe && mre) chk("both_strobes", g, 32'h1, 32'h0);
               if (mwe || mre) begin
                  if (!busy) chk("idle_strobe", g, 32'h1, 32'h0);
                  else chk("mem_addr", g, ma, base + 32'(nstrobe));
                  nstrobe++;
               end
               if (rv) begin
                  if (exp_q.size() == 0) chk("unexpected_resp", g, 32'h1, 32'h0);
                  else begin
                     e = exp_q.pop_front();
                     chk("rdata", g, rd, e[31:0]);
                     chk("error", g, {31'd0, re}, {31'd0, e[32]});
                     chk("strobes", g, 32'(nstrobe), {29'd0, e[35:33]});
                     chk("latency", g, 32'(cyc - acc_cyc), {24'd0, e[43:36]});
                  end
                  busy = 1'b0;
               end
               if (valid[g] && ready) begin
                  busy = 1'b1; acc_cyc = cyc; base = req_addr; nstrobe = 0;
               end
            end
         end
      end
   end

   // Reference model: compute the architectural result from the request and ref_mem.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      int          n, guard;
      logic        err;
      logic [63:0] v;
      logic [31:0] rdata;
      logic [1:0]  acc;
      n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      err = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0);
      rdata = '0;
      if (!err && we) begin
         for (int k = 0; k < n; k++) ref_mem[idx(addr + 32'(k))] = 8'(wd >> (8 * (n - 1 - k)));
      end else if (!err) begin
         v = '0;
         for (int k = 0; k < n; k++) v = (v << 8) | 64'(ref_mem[idx(addr + 32'(k))]);
         if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
         rdata = v[31:0];
      end
      for (int i = 0; i < 2; i++) begin
         logic [7:0]  lat;
         logic [2:0]  ns;
         logic [43:0] e;
         lat = err ? 8'd1 : we ? 8'(n + 1) : 8'(n * (2 + i) + 1);
         ns  = err ? 3'd0 : 3'(n);
         e   = {lat, ns, err, rdata};
         if (i == 0) g_inst[0].exp_q.push_back(e);
         else        g_inst[1].exp_q.push_back(e);
      end
      @(posedge clk); #1;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      valid = 2'b11;
      guard = 0;
      while (valid != 2'b00 && guard < 400) begin
         @(negedge clk);
         acc = valid & {g_inst[1].ready, g_inst[0].ready};
         @(posedge clk); #1;
         valid = valid & ~acc;
         guard++;
      end
      if (valid != 2'b00) begin
         chk("accept_timeout", 0, {30'd0, valid}, 32'h0);
         valid = 2'b00;
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((g_inst[0].exp_q.size() != 0 || g_inst[1].exp_q.size() != 0) && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 500) chk("resp_timeout", 0, 32'(g_inst[0].exp_q.size() + g_inst[1].exp_q.size()), 32'h0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic [7:0] o2, o3;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h80);
      issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h7F);
      issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h8001);
      issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
      issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
      issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
      issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678);
      issue(1'b0, 2'b10, 1'b1, 32'h100, 32'h0);

      // Reset during the third byte of a word store: only the first two bytes land.
      wait_idle();
      o2 = ref_mem[idx(32'h202)];
      o3 = ref_mem[idx(32'h203)];
      issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      g_inst[0].exp_q.delete();
      g_inst[1].exp_q.delete();
      ref_mem[idx(32'h202)] = o2;
      ref_mem[idx(32'h203)] = o3;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      issue(1'b0, 2'b10, 1'b1, 32'h200, 32'h0);

      issue(1'b1, 2'b01, 1'b0, 32'hFFFFFFFE, 32'hABCD);
      issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFE, 32'h0);
      issue(1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h0);

      for (int t = 0; t < 200; t++) begin
         int          r;
         logic [1:0]  sz;
         logic [31:0] a;
         r  = $urandom_range(0, 9);
         sz = (r == 9) ? 2'b11 : 2'(r % 3);
         a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                          : 32'h100 + 32'($urandom_range(0, 31));
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end

      wait_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
